// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, operand classes, integer limits and
// the S1 pipeline record used by the float-to-int converter.
package fpu_pkg;

   typedef enum logic [1:0] {
      RM_RNE   = 2'd0,
      RM_RTZ   = 2'd1,
      RM_FLOOR = 2'd2
   } rm_e;

   typedef enum logic [1:0] {
      CL_NORM = 2'd0,
      CL_ZERO = 2'd1,
      CL_SAT  = 2'd2,
      CL_NAN  = 2'd3
   } cls_e;

   localparam int unsigned EXP_BIAS = 127;
   localparam logic [31:0] INT_MAX  = 32'h7FFF_FFFF;
   localparam logic [31:0] INT_MIN  = 32'h8000_0000;

   // exponent at which the 24-bit significand is already an integer, and the
   // first exponent whose magnitude no longer fits a signed 32-bit result
   localparam logic [7:0]  EXP_INT  = 8'(EXP_BIAS + 23);
   localparam logic [7:0]  EXP_SAT  = 8'(EXP_BIAS + 31);
   localparam logic [31:0] FP_NEG_2P31 = 32'hCF00_0000;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [23:0] man;
      logic [1:0]  mode;
      cls_e        cls;
   } s1_t;

endpackage

// File: rtl/ftoi_round.sv
// Rounding increment decision for float-to-int conversion; mode 3 behaves as
// round-nearest-even.
module ftoi_round
   import fpu_pkg::*;
(
   input  logic       sign_i,
   input  logic       lsb_i,
   input  logic       guard_i,
   input  logic       sticky_i,
   input  logic [1:0] mode_i,
   output logic       inc_o
);

   always_comb begin
      inc_o = 1'b0;
      case (mode_i)
         RM_RTZ:   inc_o = 1'b0;
         RM_FLOOR: inc_o = sign_i && (guard_i || sticky_i);
         default:  inc_o = guard_i && (sticky_i || lsb_i);
      endcase
   end

endmodule

// File: rtl/ftoi.sv
// Two-stage float32 to int32 converter: S1 unpacks/classifies, S2 shifts,
// rounds, negates and saturates. Valid/ready on both sides.
module ftoi
   import fpu_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] x,
   input  logic [1:0]  mode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] y,
   output logic        ovf
);

   logic        s1_valid_q, s2_valid_q;
   logic        s1_load, s2_load;
   s1_t         s1_d, s1_q;
   logic [31:0] y_d, y_q;
   logic        ovf_d, ovf_q;

   logic [3:0]  lsh;
   logic [7:0]  rsh_full;
   logic [5:0]  rsh;
   logic [63:0] ext;
   logic [31:0] mag, mag_r;
   logic        guard, sticky, inc;

   assign s2_load  = !s2_valid_q || out_ready;
   assign s1_load  = !s1_valid_q || s2_load;
   assign in_ready = s1_load;

   // -2^31 is the only value at EXP_SAT that still fits, so it stays on the normal path
   always_comb begin
      s1_d.sign = x[31];
      s1_d.exp  = x[30:23];
      s1_d.man  = {1'b1, x[22:0]};
      s1_d.mode = mode;
      if (x[30:23] == 8'd0)
         s1_d.cls = CL_ZERO;
      else if (x[30:23] == 8'hFF)
         s1_d.cls = (x[22:0] != 23'd0) ? CL_NAN : CL_SAT;
      else if (x[30:23] >= EXP_SAT && x != FP_NEG_2P31)
         s1_d.cls = CL_SAT;
      else
         s1_d.cls = CL_NORM;
   end

   // right shifts past 63 are clamped; the MSB then lands in sticky, which is all that matters
   always_comb begin
      lsh      = 4'(s1_q.exp - EXP_INT);
      rsh_full = EXP_INT - s1_q.exp;
      rsh      = (rsh_full > 8'd63) ? 6'd63 : rsh_full[5:0];
      ext      = {s1_q.man, 40'd0} >> rsh;
      if (s1_q.exp >= EXP_INT) begin
         mag    = {8'd0, s1_q.man} << lsh;
         guard  = 1'b0;
         sticky = 1'b0;
      end else begin
         mag    = {8'd0, ext[63:40]};
         guard  = ext[39];
         sticky = |ext[38:0];
      end
   end

   ftoi_round u_round (
      .sign_i   (s1_q.sign),
      .lsb_i    (mag[0]),
      .guard_i  (guard),
      .sticky_i (sticky),
      .mode_i   (s1_q.mode),
      .inc_o    (inc)
   );

   assign mag_r = mag + {31'd0, inc};

   always_comb begin
      y_d   = 32'd0;
      ovf_d = 1'b0;
      case (s1_q.cls)
         CL_ZERO: begin
            y_d   = 32'd0;
            ovf_d = 1'b0;
         end
         CL_NAN: begin
            y_d   = INT_MAX;
            ovf_d = 1'b1;
         end
         CL_SAT: begin
            y_d   = s1_q.sign ? INT_MIN : INT_MAX;
            ovf_d = 1'b1;
         end
         default: begin
            y_d   = s1_q.sign ? (~mag_r + 32'd1) : mag_r;
            ovf_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid_q <= 1'b0;
         s1_q       <= '0;
      end else if (s1_load) begin
         s1_valid_q <= in_valid;
         if (in_valid)
            s1_q <= s1_d;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s2_valid_q <= 1'b0;
         y_q        <= 32'd0;
         ovf_q      <= 1'b0;
      end else if (s2_load) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            y_q   <= y_d;
            ovf_q <= ovf_d;
         end
      end
   end

   assign out_valid = s2_valid_q;
   assign y         = y_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_ftoi.sv
// Scoreboard bench for ftoi: directed vectors with hand-computed results, a
// mid-stream output stall and a reset with operands in flight.
module tb_ftoi;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] x = 32'd0;
   logic [1:0]  mode = 2'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] y;
   logic        ovf;

   ftoi dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] y;
      logic        ovf;
      int          cyc;
      bit          lat;
   } exp_t;

   typedef struct packed {
      logic [31:0] x;
      logic [1:0]  m;
      logic [31:0] y;
      logic        o;
   } vec_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_fail = 0;
   bit   lat_en = 1'b1;

   vec_t vecs [22];
   vec_t svec [8];

   initial forever begin
      @(posedge clk);
      cyc <= cyc + 1;
   end

   task automatic send(input logic [31:0] xv, input logic [1:0] m,
                       input logic [31:0] ey, input logic eo);
      bit acc = 1'b0;
      x        = xv;
      mode     = m;
      in_valid = 1'b1;
      for (int t = 0; t < 100 && !acc; t++) begin
         @(negedge clk);
         if (in_ready) acc = 1'b1;
         @(posedge clk);
         if (acc) sb.push_back('{ey, eo, cyc, lat_en});
         #1;
      end
      in_valid = 1'b0;
      if (!acc) begin
         $display("FAIL send_timeout x=%h never accepted", xv);
         $fatal(1);
      end
   endtask

   task automatic drain();
      for (int t = 0; t < 60 && sb.size() != 0; t++) begin
         @(posedge clk);
         #1;
      end
      if (sb.size() != 0) begin
         $display("FAIL drain_timeout %0d results outstanding, want 0", sb.size());
         $fatal(1);
      end
   endtask

   // monitor: reset state, in_ready vs occupancy, stall hold, ordered results
   initial begin : monitor
      exp_t e;
      bit   rstn_prev;
      bit   exp_ir;
      rstn_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            n_vec++;
            if (out_valid !== 1'b0 || y !== 32'd0 || ovf !== 1'b0) begin
               n_fail++;
               $display("FAIL reset_state out_valid=%b y=%h ovf=%b, want 0/00000000/0",
                        out_valid, y, ovf);
            end
         end else begin
            exp_ir = !(sb.size() >= 2 && !out_ready);
            if (!rstn_prev) exp_ir = 1'b1;
            n_vec++;
            if (in_ready !== exp_ir) begin
               n_fail++;
               $display("FAIL in_ready got %b want %b (cycle %0d)", in_ready, exp_ir, cyc);
            end
            if (out_valid === 1'b1) begin
               n_vec++;
               if (sb.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_output y=%h ovf=%b, want no output", y, ovf);
               end else if (out_ready) begin
                  e = sb.pop_front();
                  if (y !== e.y || ovf !== e.ovf) begin
                     n_fail++;
                     $display("FAIL result y=%h ovf=%b, want y=%h ovf=%b", y, ovf, e.y, e.ovf);
                  end
                  if (e.lat) begin
                     n_vec++;
                     if (cyc - e.cyc != 2) begin
                        n_fail++;
                        $display("FAIL latency got %0d want 2", cyc - e.cyc);
                     end
                  end
               end else begin
                  if (y !== sb[0].y || ovf !== sb[0].ovf) begin
                     n_fail++;
                     $display("FAIL stall_hold y=%h ovf=%b, want y=%h ovf=%b",
                              y, ovf, sb[0].y, sb[0].ovf);
                  end
               end
            end
         end
         rstn_prev = rstn;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      vecs = '{
         '{32'h4020_0000, 2'd0, 32'h0000_0002, 1'b0},
         '{32'h4060_0000, 2'd0, 32'h0000_0004, 1'b0},
         '{32'hC020_0000, 2'd0, 32'hFFFF_FFFE, 1'b0},
         '{32'hC020_0000, 2'd1, 32'hFFFF_FFFE, 1'b0},
         '{32'hC020_0000, 2'd2, 32'hFFFF_FFFD, 1'b0},
         '{32'hBF00_0000, 2'd2, 32'hFFFF_FFFF, 1'b0},
         '{32'hBF00_0000, 2'd0, 32'h0000_0000, 1'b0},
         '{32'h4F00_0000, 2'd0, 32'h7FFF_FFFF, 1'b1},
         '{32'hCF00_0000, 2'd0, 32'h8000_0000, 1'b0},
         '{32'h7F80_0000, 2'd0, 32'h7FFF_FFFF, 1'b1},
         '{32'hFF80_0000, 2'd0, 32'h8000_0000, 1'b1},
         '{32'h7FC0_0000, 2'd0, 32'h7FFF_FFFF, 1'b1},
         '{32'h4EFF_FFFF, 2'd0, 32'h7FFF_FF80, 1'b0},
         '{32'h8000_0001, 2'd2, 32'h0000_0000, 1'b0},
         '{32'h4020_0000, 2'd3, 32'h0000_0002, 1'b0},
         '{32'h3FC0_0000, 2'd1, 32'h0000_0001, 1'b0},
         '{32'h3F40_0000, 2'd0, 32'h0000_0001, 1'b0},
         '{32'h3F00_0000, 2'd0, 32'h0000_0000, 1'b0},
         '{32'hBE80_0000, 2'd2, 32'hFFFF_FFFF, 1'b0},
         '{32'hCF80_0000, 2'd0, 32'h8000_0000, 1'b1},
         '{32'h4B00_0001, 2'd0, 32'h0080_0001, 1'b0},
         '{32'hC124_0000, 2'd2, 32'hFFFF_FFF5, 1'b0}
      };
      svec = '{
         '{32'h3F80_0000, 2'd0, 32'h0000_0001, 1'b0},
         '{32'h4000_0000, 2'd0, 32'h0000_0002, 1'b0},
         '{32'h4040_0000, 2'd0, 32'h0000_0003, 1'b0},
         '{32'hBF80_0000, 2'd0, 32'hFFFF_FFFF, 1'b0},
         '{32'h42C8_0000, 2'd0, 32'h0000_0064, 1'b0},
         '{32'h3FC0_0000, 2'd0, 32'h0000_0002, 1'b0},
         '{32'hC0E0_0000, 2'd0, 32'hFFFF_FFF9, 1'b0},
         '{32'h3E80_0000, 2'd0, 32'h0000_0000, 1'b0}
      };

      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // directed vectors, back-to-back with out_ready high
      lat_en = 1'b1;
      for (int i = 0; i < 22; i++)
         send(vecs[i].x, vecs[i].m, vecs[i].y, vecs[i].o);
      drain();

      // 8-operand stream with a 3-cycle output stall in the middle
      lat_en = 1'b0;
      fork
         begin
            for (int i = 0; i < 8; i++)
               send(svec[i].x, svec[i].m, svec[i].y, svec[i].o);
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // reset with two operands in flight
      out_ready = 1'b0;
      send(32'h3F80_0000, 2'd0, 32'h0000_0001, 1'b0);
      send(32'h4000_0000, 2'd0, 32'h0000_0002, 1'b0);
      @(posedge clk);
      #1;
      rstn = 1'b0;
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      out_ready = 1'b1;
      rstn = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      lat_en = 1'b1;
      send(32'h4120_0000, 2'd0, 32'h0000_000A, 1'b0);
      drain();
      repeat (3) @(posedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/ftoi.md
FTOI -- requirements
Module: ftoi

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  x/mode valid this cycle.
REQ-005 in_ready  output  1  block accepts x/mode this cycle.
REQ-006 x  input  32  IEEE-754 single-precision operand.
REQ-007 mode  input  2  rounding: 0 round-nearest-even, 1 toward zero, 2 floor, 3 same as 0.
REQ-008 out_valid  output  1  y/ovf valid.
REQ-009 out_ready  input  1  consumer accepts y/ovf this cycle.
REQ-010 y  output  32  signed two's-complement integer result.
REQ-011 ovf  output  1  result saturated (out of range, Inf or NaN).

Function
REQ-012 A transfer SHALL occur on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
REQ-013 Pipeline: two register stages, S1 (unpack/classify) and S2 (shift, round, negate, saturate); y/ovf come directly from S2 registers.
REQ-014 Latency: with out_ready held high, an accepted operand SHALL appear on out_valid exactly 2 cycles after acceptance; throughput 1 per cycle.
REQ-015 Stall rule: S2 loads when !s2_valid || out_ready; S1 loads when !s1_valid || S2 loads; in_ready = S1 load enable (bubbles collapse, no combinational path from in_valid to out_valid).
REQ-016 While out_valid && !out_ready, y and ovf SHALL hold stable; no operand is dropped or duplicated.
REQ-017 Exponent field 0 (zero/denormal) SHALL be treated as +/-0, flushing denormals to zero like the other FPU blocks; result 0 in all modes, ovf 0.
REQ-018 Magnitude = {1,frac} shifted by (exp-150): left if exp>=150, right otherwise; shifted-out bits form guard and sticky.
REQ-019 RNE increments when guard && (sticky || lsb); RTZ never increments; floor increments magnitude when sign && (guard || sticky).
REQ-020 Negative results SHALL be two's-complement negated after rounding.
REQ-021 exp>=158 with finite x: saturate to 0x7FFFFFFF (positive) or 0x80000000 (negative), ovf 1; sole exception x=0xCF000000 (-2^31) gives 0x80000000 with ovf 0.
REQ-022 Inf (exp 255, frac 0): saturate by sign, ovf 1; NaN: 0x7FFFFFFF, ovf 1.
REQ-023 |x|<1: RNE gives 0 for |x|<=0.5 and +/-1 above; floor gives -1 for any negative nonzero normal; RTZ gives 0.
REQ-024 Rounding SHALL never overflow (finite floats >= 2^23 are integers); no post-round saturation path is required.

Reset
REQ-025 rstn low SHALL asynchronously clear s1_valid and s2_valid; out_valid=0, y=0, ovf=0 while in reset.
REQ-026 in_ready SHALL be 1 in the first cycle after reset release.
REQ-027 Reset mid-operation SHALL discard all in-flight operands; none appear after release.

Structure
REQ-028 Package fpu_pkg SHALL hold: rounding-mode enum (RM_RNE, RM_RTZ, RM_FLOOR), EXP_BIAS=127, INT_MAX=0x7FFFFFFF, INT_MIN=0x80000000.
REQ-029 One combinational sub-module ftoi_round SHALL compute the increment decision from sign, lsb, guard, sticky and mode.

Verification
REQ-030 out_ready=1, back-to-back RNE inputs 0x40200000 (2.5), 0x40600000 (3.5), 0xC0200000 (-2.5) -> y=2, 4, -2 on consecutive cycles, 2-cycle latency, ovf 0.
REQ-031 x=0xC0200000 with mode 1 -> -2; mode 2 -> -3; x=0xBF000000 (-0.5) mode 2 -> -1, mode 0 -> 0.
REQ-032 x=0x4F000000 (2^31) -> 0x7FFFFFFF ovf 1; 0xCF000000 -> 0x80000000 ovf 0; 0x7F800000 -> 0x7FFFFFFF ovf 1; 0x7FC00000 -> 0x7FFFFFFF ovf 1; 0x4EFFFFFF -> 2147483520 ovf 0.
REQ-033 Denormal 0x80000001 in mode 2 -> 0, ovf 0.
REQ-034 Stream 8 operands, out_ready low for 3 cycles mid-stream -> in_ready drops after both stages fill, y held stable, all 8 results in order, none lost.
REQ-035 Assert rstn low with two operands in flight -> out_valid 0 immediately; after release no stale result; next operand 0x41200000 (10.0) -> 10 after 2 cycles.
